// File: rtl/pseudo_spi_xfer.sv
// pseudo_spi_xfer: streams SRAM words to/from an analog device over SCLK1/SCLK2.
// Read-in path is built only when PSEUDO_SPI_READBACK_EN is defined.
module pseudo_spi_xfer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 8,
  parameter int DIV_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [LEN_WIDTH-1:0]  DATA_LEN,
  input  logic [DIV_WIDTH-1:0]  FREQ_DIV,
  input  logic                  MSB_FIRST,
  input  logic                  ADDR_DEC,
  input  logic [DATA_WIDTH-1:0] PI,
  input  logic                  SPI_SI,
  output logic                  SCLK1,
  output logic                  SCLK2,
  output logic                  LAT,
  output logic                  SEL,
  output logic                  SPI_SO,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  D_WE,
  output logic [DATA_WIDTH-1:0] PO,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_READ, S_SHIFT, S_WRITE, S_RDY, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                  mode_q, mode_d;
  logic                  msb_q, msb_d;
  logic                  dec_q, dec_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0]            ph_q, ph_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  sclk1_q, sclk1_d;
  logic                  sclk2_q, sclk2_d;
  logic                  lat_q, lat_d;
  logic                  so_q, so_d;
  logic                  cen_q, cen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sel_d, we_d;
  logic [DATA_WIDTH-1:0] po_d;

  logic                  mode_in;
  logic                  si_bit;
  logic                  tick;
  logic                  slot_end;
  logic                  last_bit;
  logic                  last_word;
  logic                  in_shift;
  logic [ADDR_WIDTH-1:0] step;

`ifdef PSEUDO_SPI_READBACK_EN
  logic                  sel_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] po_q;
  assign mode_in = MODE;
  assign si_bit  = mode_q & SPI_SI;
`else
  logic unused_ok;
  assign unused_ok = ^{MODE, SPI_SI, sel_d, we_d, po_d};
  assign mode_in = 1'b0;
  assign si_bit  = 1'b0;
`endif

  assign tick      = cnt_q == div_q;
  assign slot_end  = tick && ph_q == 2'd3;
  assign last_bit  = bit_q == BW'(DATA_WIDTH - 1);
  assign last_word = rem_q == LEN_WIDTH'(1);
  assign step      = dec_q ? addr_q - ADDR_WIDTH'(1)
                           : addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    msb_d   = msb_q;
    dec_d   = dec_q;
    div_d   = div_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    cnt_d   = '0;
    ph_d    = '0;
    bit_d   = '0;
    if (state_q == S_SHIFT || state_q == S_RDY) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      ph_d  = tick ? ph_q + 2'd1 : ph_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d = mode_in;
          msb_d  = MSB_FIRST;
          dec_d  = ADDR_DEC;
          div_d  = FREQ_DIV;
          rem_d  = DATA_LEN;
          addr_d = ADDR_BGN;
          if (DATA_LEN == '0) state_d = mode_in ? S_DONE : S_RDY;
          else                state_d = mode_in ? S_SHIFT : S_ADDR;
        end
      end
      S_ADDR: state_d = S_READ;
      S_READ: begin
        sr_d    = PI;
        addr_d  = step;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bit_d = bit_q;
        if (slot_end) begin
          // read-in bits enter opposite the transmit end
          sr_d = msb_q ? {sr_q[DATA_WIDTH-2:0], si_bit}
                       : {si_bit, sr_q[DATA_WIDTH-1:1]};
          if (!last_bit) begin
            bit_d = bit_q + BW'(1);
          end else begin
            bit_d = '0;
            if (mode_q) begin
              state_d = S_WRITE;
            end else begin
              rem_d   = rem_q - LEN_WIDTH'(1);
              state_d = last_word ? S_RDY : S_ADDR;
            end
          end
        end
      end
      S_WRITE: begin
        addr_d  = step;
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = last_word ? S_DONE : S_SHIFT;
      end
      S_RDY:  if (slot_end) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_shift = state_d == S_SHIFT;
    sclk1_d  = in_shift && ph_d == 2'd1;
    sclk2_d  = in_shift && ph_d == 2'd3;
    lat_d    = state_d == S_RDY;
    done_d   = state_d == S_DONE;
    busy_d   = state_d != S_IDLE;
    cen_d    = !(state_d == S_ADDR || state_d == S_WRITE);
    a_d      = cen_d ? '0 : addr_d;
    so_d     = in_shift && !mode_d &&
               (msb_d ? sr_d[DATA_WIDTH-1] : sr_d[0]);
    sel_d    = mode_d && (in_shift || state_d == S_WRITE);
    we_d     = state_d != S_WRITE;
    po_d     = (state_d == S_WRITE) ? sr_d : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      msb_q   <= 1'b0;
      dec_q   <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      sr_q    <= '0;
      sclk1_q <= 1'b0;
      sclk2_q <= 1'b0;
      lat_q   <= 1'b0;
      so_q    <= 1'b0;
      cen_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      msb_q   <= msb_d;
      dec_q   <= dec_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      sr_q    <= sr_d;
      sclk1_q <= sclk1_d;
      sclk2_q <= sclk2_d;
      lat_q   <= lat_d;
      so_q    <= so_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PSEUDO_SPI_READBACK_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sel_q <= 1'b0;
      we_q  <= 1'b1;
      po_q  <= '0;
    end else begin
      sel_q <= sel_d;
      we_q  <= we_d;
      po_q  <= po_d;
    end
  end

  assign SEL  = sel_q;
  assign D_WE = we_q;
  assign PO   = po_q;
`else
  assign SEL  = 1'b0;
  assign D_WE = 1'b1;
  assign PO   = '0;
`endif

  assign SCLK1  = sclk1_q;
  assign SCLK2  = sclk2_q;
  assign LAT    = lat_q;
  assign SPI_SO = so_q;
  assign A      = a_q;
  assign CEN    = cen_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
